// File: rtl/fp_inverse_sqrt_multi.sv
// Multi-channel FP32 reciprocal square root front end: round-robin, credit-based
// issue into one shared fixed-latency pipeline, with per-channel ordered result FIFOs.

package fp_pkg;
    typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} rmode_e;
endpackage

module fp_inverse_sqrt_pipeline
    import fp_pkg::*;
#(
    parameter int LATENCY = 3  // >= 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_data_in,
    input  logic [31:0] data_in,
    input  logic [2:0]  rmode,
    output logic        valid_data_out,
    output logic [31:0] data_out,
    output logic [4:0]  flags
);
    // Result packed as {fp32, invalid, div_by_zero, overflow, underflow, inexact}.
    // The normalised result exponent is always in range, so overflow/underflow stay 0.
    function automatic logic [36:0] rsqrt_fp32(input logic [31:0] a, input logic [2:0] rm);
        logic [7:0]  ex;
        logic [22:0] fr;
        logic [23:0] m;
        logic [24:0] m2;
        logic [26:0] q, t;
        logic [78:0] lim;
        logic [23:0] man;
        logic [24:0] sum;
        logic        g, st, up;
        int          e, half, eb, p;
        ex  = a[30:23];
        fr  = a[22:0];
        lim = 79'd1 << 75;
        if (ex == 8'hFF && fr != '0) return {32'h7FC0_0000, ~fr[22], 4'b0000};
        if (ex == '0 && fr == '0)    return {a[31], 8'hFF, 23'd0, 5'b01000};
        if (a[31])                   return {32'h7FC0_0000, 5'b10000};
        if (ex == 8'hFF)             return 37'd0;
        if (ex == '0) begin
            p = 0;
            for (int i = 0; i < 23; i++) if (fr[i]) p = i;
            m = {1'b0, fr} << (23 - p);
            e = -126 - (23 - p);
        end else begin
            m = {1'b1, fr};
            e = int'(ex) - 127;
        end
        // Make the exponent even so the square root of the scale is exact.
        if (e[0]) begin
            m2 = {m, 1'b0};
            e  = e - 1;
        end else begin
            m2 = {1'b0, m};
        end
        half = e / 2;
        // q = floor(2^26 / sqrt(m2 * 2^-23)): largest q with q*q*m2 <= 2^75.
        q = '0;
        for (int b = 26; b >= 0; b--) begin
            t = q | (27'd1 << b);
            if (79'(t) * 79'(t) * 79'(m2) <= lim) q = t;
        end
        if (q[26]) return {1'b0, 8'(127 - half), 23'd0, 5'b00000};
        man = q[25:2];
        g   = q[1];
        st  = q[0] | (79'(q) * 79'(q) * 79'(m2) != lim);
        case (rmode_e'(rm))
            RTZ, RDN: up = 1'b0;
            RUP:      up = g | st;
            RMM:      up = g;
            default:  up = g & (st | man[0]);
        endcase
        sum = {1'b0, man} + 25'(up);
        eb  = 126 - half + int'(sum[24]);
        return {1'b0, 8'(eb), (sum[24] ? 23'd0 : sum[22:0]), 4'b0000, g | st};
    endfunction

    logic [LATENCY-1:0] vld;
    logic [36:0]        stage [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld <= '0;
        else     vld <= {vld[LATENCY-2:0], valid_data_in};
    end

    // NOTE: data stages carry no reset; vld alone says which stages hold live results.
    always_ff @(posedge clk) begin
        stage[0] <= rsqrt_fp32(data_in, rmode);
        for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end

    assign valid_data_out   = vld[LATENCY-1];
    assign {data_out, flags} = stage[LATENCY-1];
endmodule

module fp_inverse_sqrt_multi #(
    parameter int NUM_CH    = 4,
    parameter int OUT_DEPTH = 4,
    parameter int TAG_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    in_valid,
    output logic [NUM_CH-1:0]    in_ready,
    input  logic [NUM_CH*32-1:0] in_data,
    input  logic [NUM_CH*3-1:0]  in_rmode,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic [NUM_CH*32-1:0] out_data,
    output logic [NUM_CH*5-1:0]  out_flags
);
    localparam int L_PIPE = 3;
    localparam int CHW    = $clog2(NUM_CH);
    localparam int AW     = $clog2(OUT_DEPTH);
    localparam int CW     = AW + 1;
    localparam int TW     = $clog2(TAG_DEPTH);
    localparam int TCW    = TW + 1;

    logic [NUM_CH-1:0] elig, grant;
    logic [CHW-1:0]    rr_ptr, gnt_idx, ret_ch;
    logic              gnt_any;
    logic              iss_vld;
    logic [31:0]       iss_data;
    logic [2:0]        iss_rm;
    logic              p_vld;
    logic [31:0]       p_data;
    logic [4:0]        p_flags;
    logic [CHW-1:0]    tag_mem [TAG_DEPTH];
    logic [TW-1:0]     tag_wr, tag_rd;
    logic [TCW-1:0]    tag_cnt;
    logic              tag_full;

    assign tag_full = (tag_cnt == TCW'(TAG_DEPTH));
    assign ret_ch   = tag_mem[tag_rd];

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        int idx;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_CH;
            if (!gnt_any && elig[idx]) begin
                gnt_any    = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = CHW'(idx);
            end
        end
    end
    assign in_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            iss_vld <= 1'b0;
            tag_wr  <= '0;
            tag_rd  <= '0;
            tag_cnt <= '0;
        end else begin
            iss_vld <= gnt_any;
            if (gnt_any) begin
                rr_ptr <= (gnt_idx == CHW'(NUM_CH - 1)) ? '0 : gnt_idx + CHW'(1);
                tag_wr <= (tag_wr == TW'(TAG_DEPTH - 1)) ? '0 : tag_wr + TW'(1);
            end
            if (p_vld) tag_rd <= (tag_rd == TW'(TAG_DEPTH - 1)) ? '0 : tag_rd + TW'(1);
            if (gnt_any && !p_vld)      tag_cnt <= tag_cnt + TCW'(1);
            else if (p_vld && !gnt_any) tag_cnt <= tag_cnt - TCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_any) begin
            iss_data        <= in_data[int'(gnt_idx)*32 +: 32];
            iss_rm          <= in_rmode[int'(gnt_idx)*3 +: 3];
            tag_mem[tag_wr] <= gnt_idx;
        end
    end

    fp_inverse_sqrt_pipeline #(.LATENCY(L_PIPE)) u_pipe (
        .clk            (clk),
        .rst            (~rst_n),
        .valid_data_in  (iss_vld),
        .data_in        (iss_data),
        .rmode          (iss_rm),
        .valid_data_out (p_vld),
        .data_out       (p_data),
        .flags          (p_flags)
    );

    // Credits: occupancy plus in-flight ops never exceed the result FIFO depth.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [36:0]   mem [OUT_DEPTH];
        logic [AW-1:0] wr, rd;
        logic [CW-1:0] cnt, infl;
        logic          push, pop;

        assign push         = p_vld && (ret_ch == CHW'(c));
        assign pop          = (cnt != '0) && out_ready[c];
        assign out_valid[c] = (cnt != '0);
        assign {out_data[c*32 +: 32], out_flags[c*5 +: 5]} = mem[rd];
        assign elig[c] = rst_n && in_valid[c] && !tag_full &&
                         (({1'b0, cnt} + {1'b0, infl}) < (CW+1)'(OUT_DEPTH));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr   <= '0;
                rd   <= '0;
                cnt  <= '0;
                infl <= '0;
            end else begin
                if (push) wr <= wr + AW'(1);
                if (pop)  rd <= rd + AW'(1);
                if (push && !pop)      cnt <= cnt + CW'(1);
                else if (pop && !push) cnt <= cnt - CW'(1);
                if (grant[c] && !push)      infl <= infl + CW'(1);
                else if (push && !grant[c]) infl <= infl - CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem[wr] <= {p_data, p_flags};
        end
    end
endmodule

// File: tb/tb_fp_inverse_sqrt_multi.sv
// Directed bench for fp_inverse_sqrt_multi: vector table on one channel, then
// back-to-back, round-robin, credit back-pressure and mid-flight reset sequences.

module tb_fp_inverse_sqrt_multi;
    localparam int NUM_CH = 4;
    localparam int L_PIPE = 3;
    localparam int NVEC   = 18;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_CH-1:0]    in_valid = '0;
    logic [NUM_CH-1:0]    in_ready;
    logic [NUM_CH*32-1:0] in_data = '0;
    logic [NUM_CH*3-1:0]  in_rmode = '0;
    logic [NUM_CH-1:0]    out_valid;
    logic [NUM_CH-1:0]    out_ready = '1;
    logic [NUM_CH*32-1:0] out_data;
    logic [NUM_CH*5-1:0]  out_flags;

    always #5 clk = ~clk;

    fp_inverse_sqrt_multi #(.NUM_CH(NUM_CH), .OUT_DEPTH(4), .TAG_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rmode(in_rmode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
    );

    typedef struct {
        logic [31:0] a;
        logic [2:0]  rm;
        logic [31:0] y;
        logic [4:0]  fl;
    } vec_t;

    vec_t        vec [NVEC];
    int          n_pass = 0;
    int          n_total = 0;
    int          stim_q [NUM_CH][$];
    int          exp_q  [NUM_CH][$];
    logic [36:0] got_q  [NUM_CH][$];
    int          grant_log [$];
    int          bubble_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Records every completed output handshake, per channel, in arrival order.
    initial forever begin
        @(negedge clk);
        #2;
        for (int c = 0; c < NUM_CH; c++)
            if (out_valid[c] && out_ready[c])
                got_q[c].push_back({out_data[c*32 +: 32], out_flags[c*5 +: 5]});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic bit all_empty();
        for (int c = 0; c < NUM_CH; c++) if (stim_q[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic queue_op(input int c, input int idx);
        stim_q[c].push_back(idx);
        exp_q[c].push_back(idx);
    endtask

    task automatic compare_channel(input int c, input string tag);
        check($sformatf("%s_ch%0d_count", tag, c), 64'(got_q[c].size()), 64'(exp_q[c].size()));
        for (int i = 0; i < got_q[c].size() && i < exp_q[c].size(); i++)
            check($sformatf("%s_ch%0d_res%0d", tag, c, i), 64'(got_q[c][i]),
                  64'({vec[exp_q[c][i]].y, vec[exp_q[c][i]].fl}));
        got_q[c].delete();
        exp_q[c].delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            got_q[c].delete();
            exp_q[c].delete();
            stim_q[c].delete();
        end
    endtask

    // Drives every channel from its stimulus queue; a channel pops its head on handshake.
    task automatic run_streams(input int max_cycles, input bit until_empty);
        int cyc;
        int left;
        bit granted;
        cyc = 0;
        grant_log.delete();
        bubble_cnt = 0;
        while (cyc < max_cycles && !(until_empty && all_empty())) begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (stim_q[c].size() > 0) begin
                    in_valid[c]          = 1'b1;
                    in_data[c*32 +: 32]  = vec[stim_q[c][0]].a;
                    in_rmode[c*3 +: 3]   = vec[stim_q[c][0]].rm;
                end else begin
                    in_valid[c] = 1'b0;
                end
            end
            #1;
            granted = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_valid[c] && in_ready[c]) begin
                    grant_log.push_back(c);
                    void'(stim_q[c].pop_front());
                    granted = 1'b1;
                end
            end
            if (!granted && in_valid != '0) bubble_cnt++;
            cyc++;
        end
        if (until_empty) begin
            left = 0;
            for (int c = 0; c < NUM_CH; c++) left += stim_q[c].size();
            check("streams_drained", 64'(left), 64'd0);
            @(negedge clk);
            in_valid = '0;
        end
    endtask

    task automatic single_op(input int c, input int idx, input string tag);
        int n;
        @(negedge clk);
        in_valid[c]         = 1'b1;
        in_data[c*32 +: 32] = vec[idx].a;
        in_rmode[c*3 +: 3]  = vec[idx].rm;
        #1;
        n = 0;
        while (!in_ready[c] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_accept"}, 64'(in_ready[c]), 64'd1);
        @(negedge clk);
        in_valid[c] = 1'b0;
        #1;
        n = 1;
        while (!out_valid[c] && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(L_PIPE + 2));
        check({tag, "_data"}, 64'(out_data[c*32 +: 32]), 64'(vec[idx].y));
        check({tag, "_flags"}, 64'(out_flags[c*5 +: 5]), 64'(vec[idx].fl));
    endtask

    initial begin
        int mism;
        // {operand, rmode, expected result, {NV,DZ,OF,UF,NX}}; rmode 0..4 = RNE,RTZ,RDN,RUP,RMM
        vec[0]  = '{32'h3E80_0000, 3'd0, 32'h4000_0000, 5'b00000};  // 0.25 -> 2
        vec[1]  = '{32'h4080_0000, 3'd0, 32'h3F00_0000, 5'b00000};  // 4 -> 0.5
        vec[2]  = '{32'h3F80_0000, 3'd0, 32'h3F80_0000, 5'b00000};  // 1 -> 1
        vec[3]  = '{32'h4180_0000, 3'd1, 32'h3E80_0000, 5'b00000};  // 16 -> 0.25
        vec[4]  = '{32'h4280_0000, 3'd3, 32'h3E00_0000, 5'b00000};  // 64 -> 0.125
        vec[5]  = '{32'h0080_0000, 3'd2, 32'h5F00_0000, 5'b00000};  // 2^-126 -> 2^63
        vec[6]  = '{32'hBF80_0000, 3'd0, 32'h7FC0_0000, 5'b10000};  // -1
        vec[7]  = '{32'h0000_0000, 3'd0, 32'h7F80_0000, 5'b01000};  // +0
        vec[8]  = '{32'h8000_0000, 3'd0, 32'hFF80_0000, 5'b01000};  // -0
        vec[9]  = '{32'h7F80_0000, 3'd0, 32'h0000_0000, 5'b00000};  // +inf
        vec[10] = '{32'h7FC0_0000, 3'd0, 32'h7FC0_0000, 5'b00000};  // qNaN
        vec[11] = '{32'h7F80_0001, 3'd0, 32'h7FC0_0000, 5'b10000};  // sNaN
        vec[12] = '{32'h4000_0000, 3'd0, 32'h3F35_04F3, 5'b00001};  // 1/sqrt2, RNE
        vec[13] = '{32'h4000_0000, 3'd3, 32'h3F35_04F4, 5'b00001};  // RUP
        vec[14] = '{32'h4000_0000, 3'd1, 32'h3F35_04F3, 5'b00001};  // RTZ
        vec[15] = '{32'h0000_0001, 3'd0, 32'h64B5_04F3, 5'b00001};  // 2^-149 -> sqrt2*2^74
        vec[16] = '{32'hFF80_0000, 3'd0, 32'h7FC0_0000, 5'b10000};  // -inf
        vec[17] = '{32'h4000_0000, 3'd4, 32'h3F35_04F3, 5'b00001};  // RMM, guard bit 0

        // Reset state, with requests already asserted.
        in_valid = '1;
        #12;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) single_op(0, i, $sformatf("vec%0d", i));
        repeat (3) @(negedge clk);
        got_q[0].delete();

        // Ch2 back-to-back: -1, +0, +inf.
        queue_op(2, 6);
        queue_op(2, 7);
        queue_op(2, 9);
        run_streams(20, 1'b1);
        check("b2b_grants", 64'(grant_log.size()), 64'd3);
        check("b2b_bubbles", 64'(bubble_cnt), 64'd0);
        repeat (12) @(negedge clk);
        compare_channel(2, "b2b");

        // All four channels, 8 ops each: strict rotation from channel 0, no idle cycles.
        do_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < 8; k++) queue_op(c, (c * 8 + k) % NVEC);
        run_streams(100, 1'b1);
        check("rr_grant_count", 64'(grant_log.size()), 64'd32);
        mism = 0;
        for (int k = 0; k < grant_log.size(); k++) if (grant_log[k] != k % NUM_CH) mism++;
        check("rr_order_errors", 64'(mism), 64'd0);
        check("rr_bubbles", 64'(bubble_cnt), 64'd0);
        repeat (12) @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) compare_channel(c, "rr");

        // Ch1 blocked: only 4 credits, ch0 unaffected; then drain and finish.
        do_reset();
        out_ready[1] = 1'b0;
        for (int k = 0; k < 6; k++) queue_op(1, k);
        for (int k = 0; k < 8; k++) queue_op(0, 6 + k);
        run_streams(30, 1'b0);
        check("blk_ch1_accepted", 64'(6 - stim_q[1].size()), 64'd4);
        check("blk_ch1_in_ready", 64'(in_ready[1]), 64'd0);
        check("blk_ch1_out_valid", 64'(out_valid[1]), 64'd1);
        check("blk_ch0_pending", 64'(stim_q[0].size()), 64'd0);
        compare_channel(0, "blk");
        out_ready[1] = 1'b1;
        run_streams(40, 1'b1);
        repeat (12) @(negedge clk);
        compare_channel(1, "blk");

        // Reset with three ops in flight: outputs drop at once, nothing stale afterwards.
        do_reset();
        queue_op(3, 0);
        queue_op(3, 1);
        queue_op(3, 2);
        run_streams(10, 1'b1);
        #1;
        rst_n    = 1'b0;
        in_valid = '1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            got_q[c].delete();
            exp_q[c].delete();
        end
        repeat (15) @(negedge clk);
        mism = 0;
        for (int c = 0; c < NUM_CH; c++) mism += got_q[c].size();
        check("midrst_stale_results", 64'(mism), 64'd0);
        single_op(0, 1, "post_rst");
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
